// File: rtl/scc_timer_pkg.sv
// Shared types, register map and helpers for the SCC timer unit.
package scc_timer_pkg;

  typedef enum logic [1:0] {
    INHIBIT = 2'b00,
    MATCH   = 2'b01,
    CAPTURE = 2'b10,
    EVCOUNT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    RISE = 2'b00,
    FALL = 2'b01,
    BOTH = 2'b10,
    NONE = 2'b11
  } edge_e;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_RELOAD  = 3'd2;
  localparam logic [2:0] REG_T0      = 3'd3;
  localparam logic [2:0] REG_T1      = 3'd4;

  // STATUS bit of the ma flag for channel ch; cap and ov sit one and two below it.
  function automatic int status_base(input int ch);
    return 14 - 3 * ch;
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic        hi,
                                             input logic        lo);
    logic [15:0] merged;
    merged = old_val;
    if (hi) merged[15:8] = new_val[15:8];
    if (lo) merged[7:0]  = new_val[7:0];
    return merged;
  endfunction

endpackage

// File: rtl/scc_timer_channel.sv
// One match/capture/event-count channel: event synchroniser, edge detect,
// Tn register and its ma/cap/ov flags.
module scc_timer_channel
  import scc_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             tick,
  input  logic [WIDTH-1:0] t0_cur,
  input  logic [WIDTH-1:0] t0_next,
  input  logic             event_pin,
  input  mode_e            mode,
  input  edge_e            edge_sel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_ma,
  input  logic             clr_cap,
  input  logic             clr_ov,
  output logic [WIDTH-1:0] tn,
  output logic             ma,
  output logic             cap,
  output logic             ov
);

  logic [2:0]       sync;
  logic             rise;
  logic             fall;
  logic             edge_hit;
  logic [WIDTH-1:0] tn_next;
  logic             ma_set;
  logic             cap_set;
  logic             ov_set;

  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];

  always_comb begin
    edge_hit = 1'b0;
    case (edge_sel)
      RISE:    edge_hit = rise;
      FALL:    edge_hit = fall;
      BOTH:    edge_hit = rise | fall;
      default: edge_hit = 1'b0;
    endcase
  end

  // Capture overrides a same-cycle CPU write; a CPU write overrides a count.
  always_comb begin
    tn_next = lane_merge(tn, wr_data, wr_hi, wr_lo);
    ma_set  = 1'b0;
    cap_set = 1'b0;
    ov_set  = 1'b0;
    case (mode)
      MATCH: begin
        if (tick && (t0_next == tn)) ma_set = 1'b1;
      end
      CAPTURE: begin
        if (edge_hit) begin
          tn_next = t0_cur;
          cap_set = 1'b1;
        end
      end
      EVCOUNT: begin
        if (edge_hit && !(wr_hi || wr_lo)) begin
          tn_next = tn + 1'b1;
          ov_set  = &tn;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync <= '0;
      tn   <= '0;
      ma   <= 1'b0;
      cap  <= 1'b0;
      ov   <= 1'b0;
    end else begin
      sync <= {sync[1:0], event_pin};
      tn   <= tn_next;
      ma   <= ma_set  | (ma  & ~clr_ma);
      cap  <= cap_set | (cap & ~clr_cap);
      ov   <= ov_set  | (ov  & ~clr_ov);
    end
  end

endmodule

// File: rtl/scc_timer_unit.sv
// SCC timer unit: bus decode, prescaler, T0/RELOAD, STATUS/CONTROL and irq,
// with NUM_CH channel instances.
module scc_timer_unit
  import scc_timer_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 96
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              cs,
  input  logic [2:0]        addr,
  input  logic              uds,
  input  logic              lds,
  input  logic              write_strobe,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              ack,
  input  logic [NUM_CH-1:0] event_in,
  output logic              irq
);

  localparam logic [7:0]  PRESC_LAST = 8'(PRESCALE - 1);
  localparam logic [15:0] CTRL_MASK  = 16'((32'h1 << (4 * NUM_CH)) - 32'h1);

  logic             accept;
  logic             wr_hi;
  logic             wr_lo;
  logic             t0_wr;
  logic             tick;
  logic             t0_tick_upd;
  logic             t0_wrap;
  logic [7:0]       presc_cnt;
  logic [WIDTH-1:0] t0;
  logic [WIDTH-1:0] t0_next;
  logic [WIDTH-1:0] reload;
  logic [15:0]      ctrl;
  logic             t0_ov;
  logic [15:0]      clr_vec;
  logic [15:0]      status_word;
  logic [15:0]      rdata;
  logic [WIDTH-1:0] tn [NUM_CH];
  logic [NUM_CH-1:0] ma;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] ov;

  assign accept = cs & (uds | lds) & ~ack;
  assign wr_hi  = accept & write_strobe & uds;
  assign wr_lo  = accept & write_strobe & lds;
  assign t0_wr  = (wr_hi | wr_lo) & (addr == REG_T0);
  assign tick   = (presc_cnt == PRESC_LAST);

  assign clr_vec = (addr == REG_STATUS) ?
                   (data_in & {{8{wr_hi}}, {8{wr_lo}}}) : 16'h0000;

  // A CPU write to T0 swallows a coincident tick, including its overflow.
  always_comb begin
    t0_next     = t0;
    t0_tick_upd = 1'b0;
    t0_wrap     = 1'b0;
    if (t0_wr) begin
      t0_next = lane_merge(t0, data_in, wr_hi, wr_lo);
    end else if (tick) begin
      t0_tick_upd = 1'b1;
      if (&t0) begin
        t0_next = reload;
        t0_wrap = 1'b1;
      end else begin
        t0_next = t0 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      presc_cnt <= '0;
      t0        <= '0;
      reload    <= '0;
      ctrl      <= '0;
      t0_ov     <= 1'b0;
    end else begin
      presc_cnt <= (tick || t0_wr) ? 8'd0 : presc_cnt + 8'd1;
      t0        <= t0_next;
      t0_ov     <= t0_wrap | (t0_ov & ~clr_vec[15]);
      if (addr == REG_RELOAD) reload <= lane_merge(reload, data_in, wr_hi, wr_lo);
      if (addr == REG_CONTROL) ctrl <= lane_merge(ctrl, data_in, wr_hi, wr_lo) & CTRL_MASK;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    localparam int BASE = status_base(n);
    logic sel_tn;
    assign sel_tn = (addr == 3'(REG_T1 + n));

    scc_timer_channel #(.WIDTH(WIDTH)) u_channel (
      .clk      (clk),
      .nReset   (nReset),
      .tick     (t0_tick_upd),
      .t0_cur   (t0),
      .t0_next  (t0_next),
      .event_pin(event_in[n]),
      .mode     (mode_e'(ctrl[4*n +: 2])),
      .edge_sel (edge_e'(ctrl[4*n+2 +: 2])),
      .wr_hi    (wr_hi & sel_tn),
      .wr_lo    (wr_lo & sel_tn),
      .wr_data  (data_in),
      .clr_ma   (clr_vec[BASE]),
      .clr_cap  (clr_vec[BASE-1]),
      .clr_ov   (clr_vec[BASE-2]),
      .tn       (tn[n]),
      .ma       (ma[n]),
      .cap      (cap[n]),
      .ov       (ov[n])
    );
  end

  always_comb begin
    status_word     = '0;
    status_word[15] = t0_ov;
    for (int n = 0; n < NUM_CH; n++) begin
      status_word[status_base(n)]     = ma[n];
      status_word[status_base(n) - 1] = cap[n];
      status_word[status_base(n) - 2] = ov[n];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_STATUS:  rdata = status_word;
      REG_CONTROL: rdata = ctrl;
      REG_RELOAD:  rdata = reload;
      REG_T0:      rdata = t0;
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (addr == 3'(REG_T1 + n)) rdata = tn[n];
        end
      end
    endcase
  end

  // Read data is sampled at acceptance and held through the ack cycle and beyond.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      data_out <= '0;
      ack      <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ack <= accept;
      irq <= |status_word;
      if (accept) data_out <= rdata;
    end
  end

endmodule

// File: doc/scc_timer_unit.md
Name: scc_timer_unit

Overview:
Parametrised successor to the SoC timer inside the 68070 core: one free-running reference counter T0 with reload and overflow, plus NUM_CH match/capture/event-count channels. It is driven by a word-wide peripheral register bus with byte lanes. It raises a level interrupt request toward the core's IPL logic. The block is instantiated in the CPU wrapper and decoded at the timer window.

Parameters:
NUM_CH, 2, number of T1..Tn channels; legal range 1..4.
WIDTH, 16, counter width; fixed at 16 while the bus is 16 bits.
PRESCALE, 96, clk cycles per counter tick; legal range 1..255.

Ports:
clk  input  1  system clock
nReset  input  1  asynchronous reset, active-low
cs  input  1  timer register window selected
addr  input  3  word index (A[3:1])
uds  input  1  upper byte lane strobe
lds  input  1  lower byte lane strobe
write_strobe  input  1  1 = write, 0 = read
data_in  input  16  write data from CPU
data_out  output  16  registered read data, valid while ack=1
ack  output  1  one-cycle access acknowledge
event_in  input  NUM_CH  asynchronous external event pins, one per channel
irq  output  1  level interrupt request

Behaviour:
- Reset (nReset=0, async): all registers, counters, prescaler, sync flops, data_out, ack and irq go to 0.
- Register map (word index):
  - 0 STATUS: bit15 t0_ov; channel n (0-based) uses bits [14-3n:12-3n] = {ma, cap, ov}; other bits read 0.
  - 1 CONTROL: channel n uses bits [4n+3:4n] = {event[1:0], mode[1:0]}.
  - 2 RELOAD.
  - 3 T0.
  - 4+n Tn.
  - Indices beyond 3+NUM_CH read 0 and ignore writes.
- Bus handshake:
  - An access is accepted on a cycle with cs & (uds|lds) & !ack.
  - ack=1 exactly one cycle later; data_out is loaded at acceptance and held until the next acceptance.
  - The CPU holds the request until it sees ack. Every access completes in 2 cycles.
- Byte lanes: uds writes [15:8], lds writes [7:0]. Side effects occur in the acceptance cycle.
- STATUS writes: write-1-to-clear per bit, lane-gated.
- Reads have no side effects.
- Prescaler:
  - Counts 0..PRESCALE-1 and issues a one-cycle tick on wrap.
  - Any write to T0 restarts the prescaler at 0.
- T0 on tick:
  - If T0 is all-ones: T0 <= RELOAD and t0_ov <= 1.
  - Otherwise T0 <= T0+1.
  - A CPU write to T0 in the same cycle wins; the tick is lost and no overflow is flagged.
- Event input path:
  - event_in passes through a 2-flop synchroniser, then a 3rd flop for edge detection.
  - An edge is seen 3 clk cycles after a pin change.
  - event[1:0] edge select: 00 rising, 01 falling, 10 both, 11 none. Pulses shorter than 1 clk may be missed.
- Channel mode[1:0]:
  - 00 inhibit: Tn is a plain read/write register with no flags.
  - 01 match: ma <= 1 on the tick where the updated T0 equals Tn. This includes equality produced by a reload.
  - 10 capture: on a selected edge, Tn <= current T0 value in that cycle and cap <= 1. A CPU write to Tn in the same cycle is overridden by the capture.
  - 11 event count: on a selected edge, Tn <= Tn+1. Wrap from all-ones to 0 sets ov. A CPU write in the same cycle wins over the increment.
- Flag precedence: when a hardware set and a CPU clear hit the same flag in the same cycle, set wins.
- Overrun: a new capture or overflow while the flag is still 1 leaves the flag at 1; no separate overrun bit.
- Mode change: takes effect the cycle after the write. Existing flags and Tn value are untouched.
- irq: registered OR of all STATUS flag bits. Asserts 1 cycle after a flag sets and drops 1 cycle after the last flag clears.
- Reset mid-access: ack is dropped immediately and the write is discarded.

Decomposition:
- Package scc_timer_pkg holds:
  - mode enum: INHIBIT, MATCH, CAPTURE, EVCOUNT.
  - edge enum: RISE, FALL, BOTH, NONE.
  - register index constants: REG_STATUS=0, REG_CONTROL=1, REG_RELOAD=2, REG_T0=3, REG_T1=4.
  - status bit position function for channel n.
- Sub-module scc_timer_channel: one per channel via generate. It contains the synchroniser, edge detect, mode logic, the Tn register and the ma/cap/ov flags. Inputs are tick, T0 next/current value, and write enables.
- The top level holds the bus decode, prescaler, T0/RELOAD, STATUS/CONTROL assembly and irq.

Test Plan:
- PRESCALE=1; write RELOAD=FFF0, T0=FFFE, wait 2 ticks -> T0=FFF0 and STATUS[15]=1; irq=1 one cycle later; write STATUS 8000 via uds -> t0_ov=0, irq drops.
- Ch0 match: T1=0010, CONTROL=0001, T0=000E -> ma (bit14) set on the tick where T0 becomes 0010, not before.
- Ch1 capture, rising edge: T0 running; toggle event_in[1] 0->1 -> exactly 3 clk later T2 holds T0 from that cycle and cap (bit10)=1; falling edge produces no capture.
- Ch0 event count, both edges: T1=FFFE, 4 edges -> T1=0002 and ov (bit12)=1.
- Simultaneous: clear t0_ov in the same cycle as an overflow tick -> flag remains 1. Write T0 on a tick cycle -> written value kept.
- Access timing: a read of T0 returns ack exactly one cycle after acceptance. Assert nReset during the ack cycle -> ack and irq are 0 immediately and all registers read 0 after release.
